// File: rtl/fifo_read_src_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_src_buf_if
//  Description : Bundle of the producer stream handshake and the register-
//                slave read port of the sample buffer. The master modport is
//                the side that drives words in and pops them out; the slave
//                modport is the buffer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_read_src_buf_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output s_valid,
        output s_data,
        output rd_en,
        input  s_ready,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  rd_en,
        output s_ready,
        output rd_data,
        output rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/fifo_read_src_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_src_buf
//  Description : Synchronous sample FIFO feeding an AXI-Lite FIFO read slave.
//                Producer side uses valid/ready with a registered ready; the
//                consumer side pops one word per rd_en strobe. Exports level,
//                almost-full and sticky overflow/underflow status plus a
//                saturating drop counter.
//                Build macro FIFO_RD_FWFT_EN selects first-word-fall-through
//                read mode; when undefined the read data is registered with
//                one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_src_buf #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  wire logic              ACLK,
    input  wire logic              ARESETN,
    fifo_read_src_buf_if.slave     bus,
    input  wire logic              clr,
    input  wire logic              stat_clr,
    output logic [DEPTH_LOG2:0]    level,
    output logic                   empty,
    output logic                   full,
    output logic                   afull,
    output logic                   ovf,
    output logic                   udf,
    output logic [15:0]            drop_cnt
);

    localparam int unsigned          c_depth     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  c_depth_lvl = (DEPTH_LOG2+1)'(c_depth);
    localparam logic [DEPTH_LOG2:0]  c_afull_lvl = (DEPTH_LOG2+1)'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [c_depth];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q,  level_d;
    logic                  s_ready_q, s_ready_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [15:0]           drop_q, drop_d;

    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_ovf_evt;
    logic w_udf_evt;

    assign w_empty   = (level_q == '0);
    // A flush wins over both transfers: neither the write nor the pop happens.
    assign w_push    = bus.s_valid & s_ready_q & ~clr;
    assign w_pop     = bus.rd_en & ~w_empty & ~clr;
    // Error events are judged on the handshake alone, independent of clr.
    assign w_ovf_evt = bus.s_valid & ~s_ready_q;
    assign w_udf_evt = bus.rd_en & w_empty;

    // Next-state for pointers, occupancy, registered ready and status.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        drop_d    = drop_q;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                level_d = level_q + 1'b1;
            end else if (w_pop && !w_push) begin
                level_d = level_q - 1'b1;
            end
        end

        // Ready looks at the post-edge occupancy only, so a pop while full
        // frees the slot for the following cycle, never the current one.
        s_ready_d = (level_d < c_depth_lvl);

        // A fresh event in the same cycle as stat_clr leaves the flag set.
        if (stat_clr) begin
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
            drop_d = '0;
        end
        if (w_ovf_evt) begin
            ovf_d = 1'b1;
            if (stat_clr) begin
                drop_d = 16'd1;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
        if (w_udf_evt) begin
            udf_d = 1'b1;
        end
    end

    // Control and status state; ready stays low throughout reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            s_ready_q <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            s_ready_q <= s_ready_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            drop_q    <= drop_d;
        end
    end

    // Storage array; contents survive reset and flush, only pointers move.
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.s_data;
        end
    end

`ifdef FIFO_RD_FWFT_EN
    // Head word falls through; masked to zero while nothing is stored.
    assign bus.rd_data  = w_empty ? '0 : mem_q[rd_ptr_q];
    assign bus.rd_valid = ~w_empty;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Registered read port: data captured on a successful pop, valid pulses once.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= w_pop;
            if (w_pop) begin
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.s_ready = s_ready_q;
    assign level       = level_q;
    assign empty       = w_empty;
    assign full        = (level_q == c_depth_lvl);
    assign afull       = (level_q >= c_afull_lvl);
    assign ovf         = ovf_q;
    assign udf         = udf_q;
    assign drop_cnt    = drop_q;

endmodule
`default_nettype wire
